pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage IF/ID/EXE/MEM/WB pipeline.
- Generalises the current no-hazard pipeline in four ways:
  - forwarding-mux selects, registered into EXE;
  - load-use stalls with configurable load latency;
  - branch and jump flush sequencing;
  - saturating stall and flush performance counters.
- Sits beside the stage modules and drives PC/IF-ID write enables, ID-EX bubble and stage flushes.

---
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, stall/flush sequencing and forwarding selects for a 5-stage pipeline
//
// Ports:
//   clk_i            rising-edge clock
//   rst_ni           asynchronous reset, active-low
//   id_rs_i/id_rt_i  source register addresses of the instruction in ID
//   id_uses_rt_i     ID instruction reads rt
//   id_jump_i        jump decoded in ID
//   exe_dest_i, exe_regwrite_i, exe_memread_i   producer currently in EXE
//   mem_dest_i, mem_regwrite_i                  producer currently in MEM
//   mem_pcsrc_i      branch taken, resolved in MEM
//   pc_write_o, ifid_write_o   front-end advance enables (low while stalling)
//   idex_bubble_o    zero ID/EX control bits this cycle
//   flush_ifid_o, flush_idex_o, flush_exmem_o   stage clears
//   fwd_a_o/fwd_b_o  registered EXE operand selects: 00 regfile, 10 MEM ALU result, 01 WB data
//   stall_cnt_o      saturating count of stall cycles
//   flush_cnt_o      saturating count of flush events
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              id_jump_i,
  input  logic [REG_AW-1:0] exe_dest_i,
  input  logic              exe_regwrite_i,
  input  logic              exe_memread_i,
  input  logic [REG_AW-1:0] mem_dest_i,
  input  logic              mem_regwrite_i,
  input  logic              mem_pcsrc_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              flush_exmem_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  typedef enum logic {RUN, STALL} state_e;
  localparam bit         MULTI     = LOAD_LAT > 1;
  localparam logic [2:0] SCNT_INIT = 3'(LOAD_LAT - 1);
  state_e           state_q, state_d;
  logic [2:0]       scnt_q, scnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             luh, stall, flush_jmp, flush_ev;
  logic             exe_fwd_a, mem_fwd_a, exe_fwd_b, mem_fwd_b;
  assign luh = exe_memread_i & exe_regwrite_i & (exe_dest_i != '0) &
               ((exe_dest_i == id_rs_i) | (id_uses_rt_i & (exe_dest_i == id_rt_i)));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q     <= RUN;
      scnt_q      <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  // scnt holds the stall cycles still owed after the current one; a taken branch abandons them
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    if (state_q == RUN) begin
      if (MULTI && !mem_pcsrc_i && luh) begin
        state_d = STALL;
        scnt_d  = SCNT_INIT;
      end
    end else if (mem_pcsrc_i || scnt_q == 3'd1) begin
      state_d = RUN;
      scnt_d  = '0;
    end else begin
      scnt_d = scnt_q - 3'd1;
    end
  end
  // A resolved branch outranks both the load-use stall and a jump in ID
  always_comb begin
    stall     = (state_q == STALL) ? !mem_pcsrc_i : (!mem_pcsrc_i & luh);
    flush_jmp = (state_q == RUN) & !mem_pcsrc_i & !luh & id_jump_i;
    flush_ev  = mem_pcsrc_i | flush_jmp;
  end
  // Outputs forced to their idle values while reset is held
  assign pc_write_o    = !rst_ni | !stall;
  assign ifid_write_o  = !rst_ni | !stall;
  assign idex_bubble_o = rst_ni & stall;
  assign flush_ifid_o  = rst_ni & flush_ev;
  assign flush_idex_o  = rst_ni & mem_pcsrc_i;
  assign flush_exmem_o = rst_ni & mem_pcsrc_i;
  // The EXE producer is one stage younger than the MEM producer, so it wins
  always_comb begin
    exe_fwd_a = exe_regwrite_i & (exe_dest_i != '0) & (exe_dest_i == id_rs_i);
    mem_fwd_a = mem_regwrite_i & (mem_dest_i != '0) & (mem_dest_i == id_rs_i);
    exe_fwd_b = id_uses_rt_i & exe_regwrite_i & (exe_dest_i != '0) & (exe_dest_i == id_rt_i);
    mem_fwd_b = id_uses_rt_i & mem_regwrite_i & (mem_dest_i != '0) & (mem_dest_i == id_rt_i);
    fwd_a_d   = (stall | mem_pcsrc_i) ? 2'b00 : exe_fwd_a ? 2'b10 : mem_fwd_a ? 2'b01 : 2'b00;
    fwd_b_d   = (stall | mem_pcsrc_i) ? 2'b00 : exe_fwd_b ? 2'b10 : mem_fwd_b ? 2'b01 : 2'b00;
  end
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall & ~&stall_cnt_q);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_ev & ~&flush_cnt_q);
  end
  assign fwd_a_o     = fwd_a_q;
  assign fwd_b_o     = fwd_b_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int AW = 5, LL = 3, CW = 16, SAT = 65535;
  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic [AW-1:0] id_rs, id_rt, exe_dest, mem_dest;
  logic          id_uses_rt, id_jump, exe_regwrite, exe_memread, mem_regwrite, mem_pcsrc;
  logic          pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, flush_exmem;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int            total = 0, bad = 0;
  int            m_left, m_stall, m_flush;
  logic [1:0]    m_fa, m_fb;
  pipe_hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .id_jump_i(id_jump), .exe_dest_i(exe_dest),
    .exe_regwrite_i(exe_regwrite), .exe_memread_i(exe_memread), .mem_dest_i(mem_dest),
    .mem_regwrite_i(mem_regwrite), .mem_pcsrc_i(mem_pcsrc), .pc_write_o(pc_write),
    .ifid_write_o(ifid_write), .idex_bubble_o(idex_bubble), .flush_ifid_o(flush_ifid),
    .flush_idex_o(flush_idex), .flush_exmem_o(flush_exmem), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear_inputs();
    {id_rs, id_rt, exe_dest, mem_dest} = '0;
    {id_uses_rt, id_jump, exe_regwrite, exe_memread, mem_regwrite, mem_pcsrc} = '0;
  endtask
  function automatic logic [1:0] sel(input logic [AW-1:0] r, input logic used);
    if (!used || r == 0) return 2'b00;
    if (exe_regwrite && exe_dest == r) return 2'b10;
    if (mem_regwrite && mem_dest == r) return 2'b01;
    return 2'b00;
  endfunction
  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    m_left = 0; m_stall = 0; m_flush = 0; m_fa = 2'b00; m_fb = 2'b00;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_ifid_write", ifid_write, 1);
    chk("rst_bubble", idex_bubble, 0);
    chk("rst_flushes", {flush_ifid, flush_idex, flush_exmem}, 0);
    chk("rst_fwd", {fwd_a, fwd_b}, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    @(negedge clk_i);
    clear_inputs();
    rst_ni = 1'b1;
  endtask
  // Called at a falling edge with the inputs already applied; consumes one clock
  task automatic step();
    logic luh, e_stall, e_fall, e_fj;
    logic [1:0] nfa, nfb;
    int nl;
    luh = exe_memread && exe_regwrite && exe_dest != 0 &&
          (exe_dest == id_rs || (id_uses_rt && exe_dest == id_rt));
    e_stall = 0; e_fall = 0; e_fj = 0; nl = m_left;
    if (mem_pcsrc) begin e_fall = 1; nl = 0; end
    else if (m_left > 0) begin e_stall = 1; nl = m_left - 1; end
    else if (luh) begin e_stall = 1; nl = LL - 1; end
    else if (id_jump) e_fj = 1;
    nfa = (e_stall || e_fall) ? 2'b00 : sel(id_rs, 1'b1);
    nfb = (e_stall || e_fall) ? 2'b00 : sel(id_rt, id_uses_rt);
    #1;
    chk("pc_write", pc_write, !e_stall);
    chk("ifid_write", ifid_write, !e_stall);
    chk("idex_bubble", idex_bubble, e_stall);
    chk("flush_ifid", flush_ifid, e_fall || e_fj);
    chk("flush_idex", flush_idex, e_fall);
    chk("flush_exmem", flush_exmem, e_fall);
    @(posedge clk_i);
    #1;
    m_left = nl;
    if (e_stall && m_stall < SAT) m_stall++;
    if ((e_fall || e_fj) && m_flush < SAT) m_flush++;
    m_fa = nfa; m_fb = nfb;
    chk("fwd_a", fwd_a, m_fa);
    chk("fwd_b", fwd_b, m_fb);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    @(negedge clk_i);
  endtask
  task automatic load_use();
    exe_memread = 1; exe_regwrite = 1; exe_dest = 8; id_rt = 8; id_uses_rt = 1; id_rs = 3;
  endtask
  initial begin
    clear_inputs();
    do_reset();
    repeat (5) step();
    chk("idle_pc_write", pc_write, 1);
    exe_dest = 5; exe_regwrite = 1; id_rs = 5;
    step();
    chk("fwd_a_exe", fwd_a, 2'b10);
    clear_inputs();
    mem_dest = 5; mem_regwrite = 1; id_rt = 5; id_uses_rt = 1;
    step();
    chk("fwd_b_mem", fwd_b, 2'b01);
    clear_inputs();
    exe_regwrite = 1; mem_regwrite = 1; id_uses_rt = 1;
    step();
    chk("fwd_zero_dest", {fwd_a, fwd_b}, 4'b0000);
    clear_inputs();
    do_reset();
    load_use();
    repeat (3) step();
    clear_inputs();
    step();
    chk("ld3_stall_cnt", stall_cnt, 3);
    load_use();
    id_uses_rt = 0;
    step();
    chk("ld_no_rt_stall_cnt", stall_cnt, 3);
    clear_inputs();
    do_reset();
    load_use();
    step();
    mem_pcsrc = 1;
    step();
    clear_inputs();
    step();
    chk("abort_flush_cnt", flush_cnt, 1);
    chk("abort_stall_cnt", stall_cnt, 1);
    load_use();
    step();
    rst_ni = 1'b0;
    #2;
    chk("midstall_rst_pc_write", pc_write, 1);
    chk("midstall_rst_bubble", idex_bubble, 0);
    do_reset();
    step();
    for (int i = 0; i < 400; i++) begin
      id_rs        = AW'($urandom_range(0, 3));
      id_rt        = AW'($urandom_range(0, 3));
      exe_dest     = AW'($urandom_range(0, 3));
      mem_dest     = AW'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom_range(0, 1));
      exe_regwrite = ($urandom % 4) != 0;
      exe_memread  = ($urandom % 3) == 0;
      mem_regwrite = ($urandom % 4) != 0;
      mem_pcsrc    = ($urandom % 10) == 0;
      id_jump      = ($urandom % 8) == 0;
      step();
    end
    clear_inputs();
    do_reset();
    mem_pcsrc = 1; id_jump = 1;
    step();
    chk("pcsrc_jump_single_event", flush_cnt, 1);
    clear_inputs();
    id_jump = 1;
    while (m_flush < SAT) step();
    step();
    chk("flush_cnt_saturated", flush_cnt, SAT);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
